// File: rtl/fpu_sequencer_pkg.sv
// ============================================================================
// Module  : fpu_sequencer_pkg
// Brief   : Shared widths, sequencer state encodings and the latched-op record.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fpu_sequencer_pkg;

  localparam int LEN_WORD  = 32;
  localparam int LEN_FUNC3 = 3;
  localparam int LEN_FUNC7 = 7;
  localparam int LEN_REG   = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [LEN_FUNC3-1:0] func3;
    logic [LEN_FUNC7-1:0] func7;
    logic [LEN_WORD-1:0]  rs1;
    logic [LEN_WORD-1:0]  rs2;
    logic [LEN_REG-1:0]   rd;
  } fpu_op_t;

  // The fpu is legitimately busy (and may answer) only in these two states.
  function automatic logic fpu_in_flight(input logic [2:0] st);
    return (st == ST_WAIT) || (st == ST_DRAIN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_watchdog.sv
// ============================================================================
// Module  : fpu_watchdog
// Brief   : Saturating cycle counter; expired once TIMEOUT-1 counts are reached.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int         W      = $clog2(TIMEOUT);
  localparam logic [W-1:0] C_LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;

  assign expired_o = (count_q == C_LAST);

  // Holding at C_LAST keeps expired asserted instead of wrapping back to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_sequencer.sv
// ============================================================================
// Module  : fpu_sequencer
// Brief   : Issue/completion controller between decode and the multi-cycle fpu.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_sequencer
  import fpu_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LEN_FUNC3-1:0] req_func3,
  input  logic [LEN_FUNC7-1:0] req_func7,
  input  logic [LEN_WORD-1:0]  req_rs1,
  input  logic [LEN_WORD-1:0]  req_rs2,
  input  logic [LEN_REG-1:0]   req_rd,
  input  logic                 flush,
  output logic                 fpu_order,
  output logic [LEN_FUNC3-1:0] fpu_func3,
  output logic [LEN_FUNC7-1:0] fpu_func7,
  output logic [LEN_WORD-1:0]  fpu_rs1,
  output logic [LEN_WORD-1:0]  fpu_rs2,
  input  logic                 fpu_calculated,
  input  logic [LEN_WORD-1:0]  fpu_rd,
  input  logic                 fpu_running,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [LEN_WORD-1:0]  wb_data,
  output logic [LEN_REG-1:0]   wb_rd,
  output logic                 wb_timeout,
  output logic                 err_proto,
  output logic                 err_timeout
);

  logic [2:0]          state_q, state_d;
  fpu_op_t             op_q;
  logic [LEN_WORD-1:0] wb_data_q;
  logic                wb_timeout_q;
  logic                err_proto_q;
  logic                err_timeout_q;

  logic w_accept;
  logic w_cap_result;
  logic w_cap_timeout;
  logic w_drain_timeout;
  logic w_stray_calc;
  logic w_wd_expired;
  logic w_unused_running;

  assign w_unused_running = fpu_running;

  fpu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rstn      (rstn),
    .clear_i   (state_q == ST_ISSUE),
    .enable_i  (fpu_in_flight(state_q)),
    .expired_o (w_wd_expired)
  );

  // Gated by rstn so the port reads not-ready for the whole reset window.
  assign req_ready    = rstn && (state_q == ST_IDLE) && !flush;
  assign w_accept     = req_valid && req_ready;
  assign w_stray_calc = fpu_calculated && !fpu_in_flight(state_q);

  always_comb begin
    state_d         = state_q;
    w_cap_result    = 1'b0;
    w_cap_timeout   = 1'b0;
    w_drain_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (fpu_calculated) begin
          state_d      = flush ? ST_IDLE : ST_DONE;
          w_cap_result = !flush;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else if (w_wd_expired) begin
          state_d       = ST_DONE;
          w_cap_timeout = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (fpu_calculated) begin
          state_d = ST_IDLE;
        end else if (w_wd_expired) begin
          state_d         = ST_IDLE;
          w_drain_timeout = 1'b1;
        end
      end
      ST_DONE: begin
        if (flush || wb_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      wb_data_q     <= '0;
      wb_timeout_q  <= 1'b0;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        op_q <= '{func3: req_func3, func7: req_func7, rs1: req_rs1,
                  rs2: req_rs2, rd: req_rd};
      end
      if (w_cap_result) begin
        wb_data_q    <= fpu_rd;
        wb_timeout_q <= 1'b0;
      end else if (w_cap_timeout) begin
        wb_data_q    <= '0;
        wb_timeout_q <= 1'b1;
      end
      if (w_stray_calc) err_proto_q <= 1'b1;
      if (w_cap_timeout || w_drain_timeout) err_timeout_q <= 1'b1;
    end
  end

  assign fpu_order   = (state_q == ST_ISSUE);
  assign fpu_func3   = op_q.func3;
  assign fpu_func7   = op_q.func7;
  assign fpu_rs1     = op_q.rs1;
  assign fpu_rs2     = op_q.rs2;
  assign wb_valid    = (state_q == ST_DONE);
  assign wb_data     = wb_data_q;
  assign wb_rd       = op_q.rd;
  assign wb_timeout  = wb_timeout_q;
  assign err_proto   = err_proto_q;
  assign err_timeout = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_sequencer.sv
// ============================================================================
// Module  : tb_fpu_sequencer
// Brief   : Directed bench for fpu_sequencer with a latency-programmable fpu model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpu_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func3;
  logic [6:0]  req_func7;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        fpu_order;
  logic [2:0]  fpu_func3;
  logic [6:0]  fpu_func7;
  logic [31:0] fpu_rs1;
  logic [31:0] fpu_rs2;
  logic        fpu_calculated;
  logic [31:0] fpu_rd;
  logic        fpu_running;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_timeout;
  logic        err_proto;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  int fpu_lat     = 4;
  bit fpu_mute    = 1'b0;
  int stray_req   = 0;
  int orders_seen = 0;
  int cyc         = 0;

  logic [31:0] wbq_data[$];
  logic [4:0]  wbq_rd[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fpu_sequencer #(
    .TIMEOUT (8)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_func3      (req_func3),
    .req_func7      (req_func7),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_rd         (req_rd),
    .flush          (flush),
    .fpu_order      (fpu_order),
    .fpu_func3      (fpu_func3),
    .fpu_func7      (fpu_func7),
    .fpu_rs1        (fpu_rs1),
    .fpu_rs2        (fpu_rs2),
    .fpu_calculated (fpu_calculated),
    .fpu_rd         (fpu_rd),
    .fpu_running    (fpu_running),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_data        (wb_data),
    .wb_rd          (wb_rd),
    .wb_timeout     (wb_timeout),
    .err_proto      (err_proto),
    .err_timeout    (err_timeout)
  );

  // fpu model: result = rs1 + rs2, calculated pulse L cycles after the order cycle.
  initial begin : fpu_model
    int          cnt;
    int          stray_seen;
    logic [31:0] pend;
    cnt            = 0;
    stray_seen     = 0;
    pend           = '0;
    fpu_calculated = 1'b0;
    fpu_rd         = '0;
    fpu_running    = 1'b0;
    forever begin
      @(negedge clk);
      fpu_calculated = 1'b0;
      if (!rstn) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            fpu_calculated = 1'b1;
            fpu_rd         = pend;
          end
        end
        if (stray_seen != stray_req) begin
          stray_seen     = stray_req;
          fpu_calculated = 1'b1;
          fpu_rd         = 32'hDEAD_BEEF;
        end
        if (fpu_order === 1'b1) begin
          orders_seen++;
          if (!fpu_mute) begin
            cnt  = fpu_lat;
            pend = fpu_rs1 + fpu_rs2;
          end
        end
      end
      fpu_running = (cnt > 0);
    end
  end

  initial begin : wb_monitor
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
        wbq_data.push_back(wb_data);
        wbq_rd.push_back(wb_rd);
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_wb(input int bound, output int n);
    n = 0;
    while (wb_valid !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [31:0] b2b_a[3]   = '{32'h0000_0001, 32'h0000_0100, 32'hFFFF_FFFF};
  logic [31:0] b2b_b[3]   = '{32'h0000_0010, 32'h0000_1000, 32'h0000_0002};
  logic [31:0] b2b_exp[3] = '{32'h0000_0011, 32'h0000_1100, 32'h0000_0001};

  initial begin : stimulus
    int n;
    int o0;
    int qs;
    int acc[3];
    bit saw_wb;

    rstn      = 1'b0;
    req_valid = 1'b0;
    req_func3 = 3'd7;
    req_func7 = 7'h04;
    req_rs1   = '0;
    req_rs2   = '0;
    req_rd    = '0;
    flush     = 1'b0;
    wb_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_outs", {wb_valid, fpu_order, wb_timeout, err_proto, err_timeout}, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // Basic op, L=4
    fpu_lat = 4;
    o0      = orders_seen;
    send(32'h3f80_0000, 32'h4000_0000, 5'd7);
    check("basic_order", fpu_order, 1);
    check("basic_operands", {fpu_rs1, fpu_rs2}, {32'h3f80_0000, 32'h4000_0000});
    check("basic_func", {fpu_func3, fpu_func7}, {3'd7, 7'h04});
    check("basic_busy", req_ready, 0);
    wait_wb(20, n);
    check("basic_latency", n, 5);
    check("basic_data", wb_data, 32'h7f80_0000);
    check("basic_rd_to", {wb_rd, wb_timeout}, {5'd7, 1'b0});
    check("basic_order_count", orders_seen - o0, 1);
    @(negedge clk);
    check("basic_idle", {wb_valid, req_ready}, 2'b01);

    // Writeback backpressure
    wb_ready = 1'b0;
    send(32'h0000_0010, 32'h0000_0020, 5'd12);
    wait_wb(20, n);
    check("bp_latency", n, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {wb_valid, req_ready, wb_rd, wb_data}, {1'b1, 1'b0, 5'd12, 32'h0000_0030});
    end
    wb_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {wb_valid, req_ready}, 2'b01);

    // Flush in WAIT, L=6, flush sampled at T+3
    fpu_lat = 6;
    send(32'h1, 32'h2, 5'd3);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush  = 1'b0;
    saw_wb = 1'b0;
    n      = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      if (wb_valid === 1'b1) saw_wb = 1'b1;
      @(negedge clk);
      n++;
    end
    check("flush_drain_len", n, 4);
    check("flush_no_wb", {saw_wb, wb_valid}, 0);
    check("flush_errs", {err_proto, err_timeout}, 0);

    // Back-to-back, L=1, req_valid held
    fpu_lat   = 1;
    qs        = wbq_data.size();
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_rs1 = b2b_a[i];
      req_rs2 = b2b_b[i];
      req_rd  = 5'(i + 1);
      wait_ready(20, n);
      acc[i] = cyc;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_spacing_01", acc[1] - acc[0], 4);
    check("b2b_spacing_12", acc[2] - acc[1], 4);
    check("b2b_count", wbq_data.size() - qs, 3);
    for (int i = 0; i < 3; i++) begin
      if (qs + i < wbq_data.size())
        check("b2b_result", {wbq_rd[qs+i], wbq_data[qs+i]}, {5'(i + 1), b2b_exp[i]});
    end

    // Timeout, TIMEOUT=8, fpu silent
    fpu_mute = 1'b1;
    send(32'hAAAA_0000, 32'h0000_5555, 5'd9);
    wait_wb(30, n);
    check("to_latency", n, 9);
    check("to_flags", {wb_timeout, err_timeout, err_proto}, 3'b110);
    check("to_data_rd", {wb_rd, wb_data}, {5'd9, 32'h0});
    @(negedge clk);
    check("to_idle", {wb_valid, req_ready}, 2'b01);
    fpu_mute = 1'b0;
    stray_req++;
    repeat (3) @(negedge clk);
    check("stray_err_proto", err_proto, 1);
    check("stray_ignored", {wb_valid, req_ready}, 2'b01);

    // Reset asserted in WAIT
    fpu_mute = 1'b1;
    send(32'h1234_5678, 32'h1, 5'd4);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rstw_outs", {fpu_order, wb_valid, req_ready, wb_timeout, err_proto, err_timeout}, 0);
    check("rstw_regs", {fpu_rs1, wb_rd}, 0);
    @(negedge clk);
    rstn     = 1'b1;
    fpu_mute = 1'b0;
    @(negedge clk);
    check("rstw_idle", req_ready, 1);

    // Reset asserted in DONE
    fpu_lat  = 2;
    wb_ready = 1'b0;
    send(32'h7, 32'h8, 5'd21);
    wait_wb(20, n);
    check("rstd_latency", n, 3);
    #2 rstn = 1'b0;
    #1;
    check("rstd_outs", {wb_valid, wb_timeout, wb_rd, wb_data}, 0);
    @(negedge clk);
    rstn     = 1'b1;
    wb_ready = 1'b1;
    @(negedge clk);

    // Fresh op after reset
    fpu_lat = 3;
    send(32'h4040_0000, 32'h0000_0005, 5'd31);
    wait_wb(20, n);
    check("fresh_latency", n, 4);
    check("fresh_result", {wb_rd, wb_timeout, wb_data}, {5'd31, 1'b0, 32'h4040_0005});
    @(negedge clk);
    check("fresh_idle", {wb_valid, req_ready, err_proto, err_timeout}, 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
